// File: rtl/alu_result_bcd_if.sv
// alu_result_bcd_if: start/busy/done bundle for the result BCD stage.
// master drives the request, slave is the converter.
interface alu_result_bcd_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/alu_result_bcd.sv
// alu_result_bcd: iterative double-dabble of the ALU result, 1 bit/clk.
// Optional macro RESULT_BLANK_EN: blank leading zero digits with 4'hF.
module alu_result_bcd #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_result_bcd_if.slave io
);

  localparam int BW   = 4 * DIGITS;
  localparam int ITW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam logic [BW-1:0] SAT = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_nx;
  logic [BW-1:0]    sc_q, sc_nx, adj, res;
  logic [ITW-1:0]   it_q;
  logic             ovfn_q, ovf_q;
  logic [BW-1:0]    bcd_q;
  logic             last, big;
`ifdef RESULT_BLANK_EN
  logic             lead;
`endif

  assign big  = 32'(io.bin_in) > 32'(MAXV);
  assign last = it_q == ITW'(WIDTH - 1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // add-3 on digits >= 5, then shift scratch and binary together
  always_comb begin
    adj = sc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sc_q[4*i+:4] >= 4'd5)
        adj[4*i+:4] = sc_q[4*i+:4] + 4'd3;
    end
    {sc_nx, sh_nx} = {adj, sh_q} << 1;
  end

  // final result: saturate on overflow, optionally blank leading zeros
  always_comb begin
    res = ovfn_q ? SAT : sc_nx;
`ifdef RESULT_BLANK_EN
    lead = 1'b1;
    if (!ovfn_q) begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && res[4*i+:4] == 4'h0) res[4*i+:4] = 4'hF;
        else                             lead = 1'b0;
      end
    end
`endif
  end

  // datapath: latch on start, iterate in SHIFT, publish on the last shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      sc_q   <= '0;
      it_q   <= '0;
      ovfn_q <= 1'b0;
      ovf_q  <= 1'b0;
      bcd_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.start) begin
            sh_q   <= io.bin_in;
            sc_q   <= '0;
            it_q   <= '0;
            ovfn_q <= big;
          end
        end
        SHIFT: begin
          sh_q <= sh_nx;
          sc_q <= sc_nx;
          it_q <= it_q + 1'b1;
          if (last) begin
            bcd_q <= res;
            ovf_q <= ovfn_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.busy = state_q == SHIFT;
  assign io.done = state_q == DONE;
  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// tb_alu_result_bcd: directed scoreboard bench for alu_result_bcd.
// Expected BCD comes from a decimal-division model of the input.
module tb_alu_result_bcd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_bcd_if io ();

  alu_result_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_bcd = 16'h0;
  logic [16:0] sb[$];

  function automatic logic [16:0] model(input int v);
    logic [15:0] b;
    int          x;
    logic        lead;
    x = (v > 9999) ? 9999 : v;
    for (int d = 0; d < 4; d++) begin
      b[4*d+:4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef RESULT_BLANK_EN
    lead = 1'b1;
    if (v <= 9999) begin
      for (int d = 3; d > 0; d--) begin
        if (lead && b[4*d+:4] == 4'h0) b[4*d+:4] = 4'hF;
        else                           lead = 1'b0;
      end
    end
`else
    lead = 1'b0;
`endif
    return {(v > 9999) ? 1'b1 : lead & 1'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input int v);
    logic [16:0] e;
    int          cyc;
    int          bc;
    logic        stable;
    @(negedge clk);
    io.start  = 1'b1;
    io.bin_in = 14'(v);
    sb.push_back(model(v));
    @(posedge clk);
    #1;
    io.start  = 1'b0;
    io.bin_in = 14'($urandom);
    cyc = 1;
    bc = 0;
    stable = 1'b1;
    while (!io.done && cyc < 40) begin
      if (io.busy) bc++;
      if (io.bcd !== last_bcd) stable = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_seen", 32'(io.done), 1);
    chk("latency", cyc, 15);
    chk("busy_cycles", bc, 14);
    chk("bcd_stable_busy", 32'(stable), 1);
    chk("busy_in_done", 32'(io.busy), 0);
    chk("sb_depth", sb.size(), 1);
    e = (sb.size() != 0) ? sb.pop_front() : 17'h0;
    chk("bcd", 32'(io.bcd), 32'(e[15:0]));
    chk("ovf", 32'(io.ovf), 32'(e[16]));
    last_bcd = e[15:0];
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(io.done), 0);
    chk("bcd_hold", 32'(io.bcd), 32'(last_bcd));
  endtask

  initial begin
    logic [16:0] e;
    int          ndone;
    int          first;
    int          second;

    io.start  = 1'b0;
    io.bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(io.busy), 0);
    chk("rst_done", 32'(io.done), 0);
    chk("rst_bcd", 32'(io.bcd), 0);
    chk("rst_ovf", 32'(io.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(3);
    convert(7742);
    convert(0);
    convert(9999);
    convert(12000);
    convert(729);

    // start held high, input changes mid-conversion
    @(negedge clk);
    io.start  = 1'b1;
    io.bin_in = 14'd2;
    sb.push_back(model(2));
    ndone = 0;
    first = 0;
    second = 0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) io.bin_in = 14'd5;
      if (io.done) begin
        ndone++;
        if (ndone == 1) first = c;
        else            second = c;
        e = (sb.size() != 0) ? sb.pop_front() : 17'h0;
        chk("held_bcd", 32'(io.bcd), 32'(e[15:0]));
        chk("held_ovf", 32'(io.ovf), 32'(e[16]));
        if (ndone == 1) sb.push_back(model(5));
      end
      if (c == 31) io.start = 1'b0;
    end
    chk("held_ndone", ndone, 2);
    chk("held_first", first, 15);
    chk("held_second", second, 31);
    last_bcd = model(5) & 17'hFFFF;
    repeat (2) @(posedge clk);

    convert(16383);

    // reset mid-conversion
    @(negedge clk);
    io.start  = 1'b1;
    io.bin_in = 14'd1234;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_pre_rst", 32'(io.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(io.busy), 0);
    chk("arst_done", 32'(io.done), 0);
    chk("arst_bcd", 32'(io.bcd), 0);
    chk("arst_ovf", 32'(io.ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (io.done) ndone++;
    end
    chk("no_done_abort", ndone, 0);
    last_bcd = 16'h0;

    convert(1234);
    convert(10000);
    convert(9998);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
